// File: rtl/data_mem_responder_if.sv
// CPU data-memory port: a request channel (CPU -> memory) and a response channel (memory -> CPU).
// Both channels: a transfer happens on a rising edge where valid && ready; the sender holds its payload stable while valid is high and unaccepted.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory port: one outstanding load/store, serviced from a
// word array after LATENCY wait states, answered over a valid/ready response channel.
module data_mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  bus,
   output logic [1:0]           dbg_state
);

   localparam int AW = $clog2(DEPTH);

   generate
      if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
         $error("data_mem_responder: LATENCY must be in 0..15");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("data_mem_responder: DEPTH must be a power of two >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    be_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic          accept;
   logic          access;
   logic          addr_err;
   logic [AW-1:0] idx;
   logic [31:0]   mem [DEPTH];

   assign idx      = addr_q[AW+1:2];
   assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.req_valid)  state_nxt = WAIT;
         WAIT:    if (cnt == 4'd0)    state_nxt = RESP;
         RESP:    if (bus.resp_ready) state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = (state == IDLE);
      bus.resp_valid = (state == RESP);
      accept         = (state == IDLE) && bus.req_valid;
      access         = (state == WAIT) && (cnt == 4'd0);
   end

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign dbg_state      = state;

   // Reset drops any captured request; since the write is gated by state, a store caught in WAIT never lands.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            cnt     <= 4'(LATENCY);
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (access) begin
            err_q   <= addr_err;
            rdata_q <= (addr_err || we_q) ? 32'd0 : mem[idx];
         end
      end
   end

   // Array is deliberately not reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (access && we_q && !addr_err) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance for data/error/backpressure/reset
// cases and a LATENCY=0 instance for back-to-back turnaround.
module tb_data_mem_responder;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_a;
   logic [1:0] dbg_b;
   int         n_vec;
   int         n_bad;

   data_mem_responder_if bus_a ();
   data_mem_responder_if bus_b ();

   data_mem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_a),
      .dbg_state (dbg_a)
   );

   data_mem_responder #(.DEPTH(1024), .LATENCY(0)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_b),
      .dbg_state (dbg_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one request on bus_a, return cycles from accept edge to resp_valid.
   task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output int lat);
      int n;
      check("req_ready_before", {31'd0, bus_a.req_ready}, 32'd1);
      bus_a.req_we    = we;
      bus_a.req_addr  = addr;
      bus_a.req_wdata = wdata;
      bus_a.req_be    = be;
      bus_a.req_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.req_valid = 1'b0;
      n = 0;
      while (!bus_a.resp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("resp_valid_seen", {31'd0, bus_a.resp_valid}, 32'd1);
      lat = n;
   endtask

   task automatic take_resp(output logic [31:0] rdata, output logic err);
      rdata = bus_a.resp_rdata;
      err   = bus_a.resp_err;
      bus_a.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus_a.resp_ready = 1'b0;
      check("idle_after_resp", {30'd0, bus_a.resp_valid, bus_a.req_ready}, 32'd1);
   endtask

   task automatic access_a(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] exp_rdata, input logic exp_err);
      int          lat;
      logic [31:0] rd;
      logic        er;
      send_req(we, addr, wdata, be, lat);
      take_resp(rd, er);
      check({tag, "_lat"}, lat, 32'd3);
      check({tag, "_rdata"}, rd, exp_rdata);
      check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
   endtask

   initial begin
      int lat;
      n_vec = 0;
      n_bad = 0;
      rst = 1'b0;
      bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
      bus_a.req_wdata = '0;   bus_a.req_be = '0;   bus_a.resp_ready = 1'b0;
      bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
      bus_b.req_wdata = '0;   bus_b.req_be = '0;   bus_b.resp_ready = 1'b1;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
      check("rst_rdata", bus_a.resp_rdata, 32'd0);
      check("rst_err", {31'd0, bus_a.resp_err}, 32'd0);
      check("rst_state", {30'd0, dbg_a}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // 1: store then load
      access_a("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'd0, 1'b0);
      access_a("ld10", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

      // 2: byte enables
      access_a("st20", 1'b1, 32'h20, 32'hDEADBEEF, 4'b1111, 32'd0, 1'b0);
      access_a("st20be", 1'b1, 32'h20, 32'h11223344, 4'b0101, 32'd0, 1'b0);
      access_a("ld20", 1'b0, 32'h20, 32'h0, 4'b1010, 32'hDE22BE44, 1'b0);
      access_a("st20nop", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0);
      access_a("ld20b", 1'b0, 32'h20, 32'h0, 4'b0000, 32'hDE22BE44, 1'b0);

      // 3: backpressure
      send_req(1'b0, 32'h20, 32'h0, 4'b0000, lat);
      check("bp_lat", lat, 32'd3);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {31'd0, bus_a.resp_valid}, 32'd1);
         check("bp_rdata", bus_a.resp_rdata, 32'hDE22BE44);
         check("bp_req_ready", {31'd0, bus_a.req_ready}, 32'd0);
         check("bp_state", {30'd0, dbg_a}, 32'd2);
         @(posedge clk); #1;
      end
      begin
         logic [31:0] rd;
         logic        er;
         take_resp(rd, er);
         check("bp_final_rdata", rd, 32'hDE22BE44);
      end

      // 4: errors, and no aliasing of an out-of-range store onto word 0
      access_a("st0", 1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, 32'd0, 1'b0);
      access_a("ld13", 1'b0, 32'h13, 32'h0, 4'b0000, 32'd0, 1'b1);
      access_a("st_oor", 1'b1, 32'd4096, 32'hFFFFFFFF, 4'b1111, 32'd0, 1'b1);
      access_a("st_mis", 1'b1, 32'h2, 32'hFFFFFFFF, 4'b1111, 32'd0, 1'b1);
      access_a("ld0", 1'b0, 32'h0, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);

      // 5: reset while the store waits
      access_a("st40z", 1'b1, 32'h40, 32'h0, 4'b1111, 32'd0, 1'b0);
      bus_a.req_we = 1'b1; bus_a.req_addr = 32'h40;
      bus_a.req_wdata = 32'h55AA55AA; bus_a.req_be = 4'b1111;
      bus_a.req_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rw_state_wait", {30'd0, dbg_a}, 32'd1);
      rst = 1'b0;
      #1;
      check("rw_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
      check("rw_resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
      check("rw_state", {30'd0, dbg_a}, 32'd0);
      @(posedge clk); #1;
      check("rw_held_idle", {30'd0, dbg_a}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rw_after_valid", {31'd0, bus_a.resp_valid}, 32'd0);
      access_a("ld40", 1'b0, 32'h40, 32'h0, 4'b0000, 32'd0, 1'b0);

      // 6: LATENCY=0, resp_ready tied high, req_valid held
      bus_b.req_we = 1'b1; bus_b.req_addr = 32'h8;
      bus_b.req_wdata = 32'h12345678; bus_b.req_be = 4'b1111;
      bus_b.req_valid = 1'b1;
      @(posedge clk); #1;
      bus_b.req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("b_idle", {30'd0, dbg_b}, 32'd0);
      bus_b.req_we = 1'b0;
      bus_b.req_valid = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         check("b_resp_valid", {31'd0, bus_b.resp_valid}, (k % 3 == 2) ? 32'd1 : 32'd0);
         check("b_req_ready", {31'd0, bus_b.req_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
         if (k % 3 == 2) check("b_rdata", bus_b.resp_rdata, 32'h12345678);
      end
      bus_b.req_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
